usrt_tx_shifter: RTL and testbench
==================================

# usrt_tx_shifter

Serial transmit stage of the USRT. It sits directly downstream of the parity/framing generator and accepts one 11-bit frame per valid/ready handshake. The frame is ordered {start, data[7:0], parity, stop}. The block shifts the frame out MSB-first on o_Tx and generates the synchronous bit clock o_Sclk alongside it, so the remote receiver samples on the o_Sclk rising edge.

## Interface
- CLKS_PER_BIT, default 16: i_Clk cycles per serial bit. Must be even and ≥ 2; an odd or smaller value is a compile-time error.
- i_Clk, in, 1: system clock. All logic is on the rising edge.
- i_Rst_n, in, 1: reset, asynchronous, active-low. Deassertion is synchronous to i_Clk.
- i_Valid, in, 1: i_Data holds a frame to send.
- o_Ready, out, 1: block can accept a frame. High only in IDLE.
- i_Data, in, 11: frame. Bit 10 = start, bits 9..2 = data[7:0], bit 1 = parity, bit 0 = stop.
- i_Parity, in, 2: parity mode, 00 none / 01 even / 10 odd. Used only when the configuration macro is defined.
- o_Tx, out, 1: serial data line. Idles high.
- o_Sclk, out, 1: serial bit clock. Low while idle.
- o_Busy, out, 1: high from the handshake until o_Done.
- o_Done, out, 1: single-cycle pulse after the last bit period ends.

## Operation
- Reset values: o_Tx=1, o_Sclk=0, o_Ready=1, o_Busy=0, o_Done=0, state=IDLE, all counters 0.
- The handshake fires on a cycle where i_Valid && o_Ready is true at the clock edge. On that edge the block captures i_Data (and i_Parity) into the shift register and enters SHIFT.
- States:
  - IDLE → SHIFT on handshake.
  - SHIFT → DONE after the last bit period completes.
  - DONE → IDLE unconditionally after one cycle.
- SHIFT behaviour:
  - o_Tx drives the current MSB of the shift register.
  - Bit counter cyc runs 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1 the register shifts left, the bit index increments and cyc wraps to 0.
- o_Sclk is registered: low for cyc 0..N/2-1 and high for cyc N/2..N-1. This puts the rising edge at mid-bit.
- DONE: o_Done=1, o_Tx=1, o_Sclk=0, o_Ready=0.
- Changes on i_Data, i_Parity or i_Valid while not in IDLE are ignored; no frame is lost or merged.
- Asserting i_Rst_n low mid-frame returns every output to its reset value immediately. The partial frame is dropped and no o_Done is produced.
- Widths: cyc uses $clog2(CLKS_PER_BIT) bits; the bit index uses 4 bits and counts 0..10. No other arithmetic is performed.

## Timing
- The handshake happens at edge 0. In the figures below, N = CLKS_PER_BIT.
- Bit k (k = 0 is the start bit) is on o_Tx during cycles 1+k·N through (k+1)·N.
- An 11-bit frame occupies cycles 1..11N. o_Done and o_Busy→0 occur in cycle 11N+1. o_Ready rises in cycle 11N+2.
- Back-to-back frames have a minimum gap of one DONE cycle plus one IDLE cycle, with o_Tx=1 throughout the gap.
- Sclk rising edges fall at cycle N/2+1+k·N, one per bit.

## Configuration
- USRT_TX_SKIP_NOPARITY_EN:
  - Defined: i_Parity is captured at the handshake. If it is 2'b00, the parity slot (frame bit 1) is not transmitted, the frame is 10 bits and o_Done arrives at cycle 10N+1. For 01 and 10 all 11 bits are sent.
  - Undefined: i_Parity is ignored, and all 11 bits are always sent, including parity = 0 in no-parity mode.

## Structure
- Shared package usrt_pkg holds:
  - FRAME_W = 11.
  - Parity constants PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10.
  - The state enum tx_state_t {IDLE, SHIFT, DONE}.
  - Frame bit positions START_POS = 10, PAR_POS = 1, STOP_POS = 0.
- One sub-module, usrt_baud_tick, holds the cyc counter and emits sclk and bit_end (cyc == N-1), with an enable and a sync clear. The shifter FSM instantiates it.

## Test plan
- Basic frame, N=4, frame 11'h295 (data 8'hA5, even parity 0), i_Valid pulsed one cycle.
  - o_Tx must show 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles.
  - o_Done pulses in cycle 45; 11 o_Sclk rising edges at cycles 3, 7, …, 43.
- Back-to-back, N=4: i_Valid held high with frames 11'h295 then 11'h003.
  - The second start bit appears at cycle 47.
  - o_Tx=1 in cycles 45–46; exactly two o_Done pulses.
- Input stability, N=4: change i_Data to 11'h7FF at cycle 10 of frame 11'h295.
  - The transmitted sequence is unchanged; o_Ready stays low until cycle 46.
- Reset mid-frame, N=4: pull i_Rst_n low at cycle 20.
  - In the same cycle, o_Tx=1, o_Sclk=0, o_Busy=0 and o_Ready=1.
  - No o_Done; the next handshake sends a full frame.
- Macro defined, i_Parity=00, frame 11'h295, N=4.
  - o_Tx must show 0,1,0,1,0,0,1,0,1,1 (10 bits); o_Done in cycle 41.
  - Repeat with i_Parity=01: 11 bits, o_Done in cycle 45.
- N=2 corner: frame 11'h400.
  - o_Tx shows 1,0 ×9 bits … exactly as frame bits, each held 2 cycles.
  - o_Sclk pattern is 0,1 per bit; o_Done in cycle 23.

Source files
------------

// File: rtl/usrt_pkg.sv
// Shared USRT definitions: frame layout, parity modes and transmit FSM states.
package usrt_pkg;

   localparam int FRAME_W   = 11;
   localparam int START_POS = 10;
   localparam int PAR_POS   = 1;
   localparam int STOP_POS  = 0;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam logic [3:0] LAST_IDX_FULL = 4'd10;
   localparam logic [3:0] LAST_IDX_SKIP = 4'd9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } tx_state_t;

   // Close the parity gap: stop moves into the parity slot, the tail is idle-high.
   function automatic logic [FRAME_W-1:0] drop_parity(input logic [FRAME_W-1:0] f);
      return {f[START_POS:PAR_POS+1], f[STOP_POS], 1'b1};
   endfunction

endpackage

// File: rtl/usrt_baud_tick.sv
// Bit-period counter: cyc runs 0..N-1, registered sclk is high for the second half.
module usrt_baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic i_Clk,
   input  logic i_Rst_n,
   input  logic i_En,
   input  logic i_Clr,
   output logic o_Sclk,
   output logic o_Bit_end
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

   logic [CW-1:0] r_cyc;
   logic [CW-1:0] w_cyc_nxt;
   logic          r_sclk;

   assign w_cyc_nxt = (r_cyc == LAST) ? '0 : r_cyc + 1'b1;
   assign o_Bit_end = i_En && (r_cyc == LAST);
   assign o_Sclk    = r_sclk;

   // sclk follows the next cyc value so it lines up with cyc in the same cycle.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_cyc  <= '0;
         r_sclk <= 1'b0;
      end else if (i_Clr) begin
         r_cyc  <= '0;
         r_sclk <= 1'b0;
      end else if (i_En) begin
         r_cyc  <= w_cyc_nxt;
         r_sclk <= (w_cyc_nxt >= HALF);
      end
   end

endmodule

// File: rtl/usrt_tx_shifter.sv
// USRT serial transmit stage: shifts an 11-bit frame MSB-first with a mid-bit sclk.
// Optional feature: define USRT_TX_SKIP_NOPARITY_EN to omit the parity slot when i_Parity is none.
module usrt_tx_shifter
   import usrt_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic               i_Clk,
   input  logic               i_Rst_n,
   input  logic               i_Valid,
   output logic               o_Ready,
   input  logic [FRAME_W-1:0] i_Data,
   input  logic [1:0]         i_Parity,
   output logic               o_Tx,
   output logic               o_Sclk,
   output logic               o_Busy,
   output logic               o_Done
);

   if ((CLKS_PER_BIT < 2) || ((CLKS_PER_BIT % 2) != 0)) begin : g_bad_cfg
      $error("usrt_tx_shifter: CLKS_PER_BIT must be even and >= 2");
   end

   tx_state_t          r_state;
   tx_state_t          w_state_nxt;
   logic [FRAME_W-1:0] r_shift;
   logic [3:0]         r_idx;
   logic [3:0]         r_last;
   logic [FRAME_W-1:0] w_load;
   logic [3:0]         w_last;
   logic               w_sclk;
   logic               w_bit_end;
   logic               w_in_shift;
   logic               w_accept;

   assign w_in_shift = (r_state == SHIFT);
   assign w_accept   = (r_state == IDLE) && i_Valid;

`ifdef USRT_TX_SKIP_NOPARITY_EN
   logic w_skip;
   assign w_skip = (i_Parity == PAR_NONE);
   assign w_load = w_skip ? drop_parity(i_Data) : i_Data;
   assign w_last = w_skip ? LAST_IDX_SKIP : LAST_IDX_FULL;
`else
   logic w_unused_par;
   assign w_unused_par = ^i_Parity;
   assign w_load       = i_Data;
   assign w_last       = LAST_IDX_FULL;
`endif

   usrt_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .i_Clk     (i_Clk),
      .i_Rst_n   (i_Rst_n),
      .i_En      (w_in_shift),
      .i_Clr     (!w_in_shift),
      .o_Sclk    (w_sclk),
      .o_Bit_end (w_bit_end)
   );

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (i_Valid) w_state_nxt = SHIFT;
         SHIFT:   if (w_bit_end && (r_idx == r_last)) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_Ready = 1'b0;
      o_Busy  = 1'b0;
      o_Done  = 1'b0;
      o_Tx    = 1'b1;
      o_Sclk  = 1'b0;
      case (r_state)
         IDLE:  o_Ready = 1'b1;
         SHIFT: begin
            o_Busy = 1'b1;
            o_Tx   = r_shift[FRAME_W-1];
            o_Sclk = w_sclk;
         end
         DONE:  o_Done = 1'b1;
         default: ;
      endcase
   end

   // Frame capture and MSB-first shifting; the index stops at the last bit.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_shift <= '1;
         r_idx   <= '0;
         r_last  <= LAST_IDX_FULL;
      end else if (w_accept) begin
         r_shift <= w_load;
         r_idx   <= '0;
         r_last  <= w_last;
      end else if (w_in_shift && w_bit_end && (r_idx != r_last)) begin
         r_shift <= {r_shift[FRAME_W-2:0], 1'b1};
         r_idx   <= r_idx + 4'd1;
      end
   end

endmodule

// File: tb/tb_usrt_tx_shifter.sv
// Scoreboard bench for usrt_tx_shifter: per-cycle expected line states queued per frame.
module tb_usrt_tx_shifter;
   import usrt_pkg::*;

   localparam int N1 = 4;
   localparam int N2 = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid1 = 1'b0, valid2 = 1'b0;
   logic [10:0] data = '0;
   logic [1:0]  par = PAR_EVEN;
   logic        rdy1, tx1, sclk1, busy1, done1;
   logic        rdy2, tx2, sclk2, busy2, done2;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic tx;
      logic sclk;
      logic done;
      logic busy;
      logic ready;
   } obs_t;

   obs_t exp_q[$];

   always #5 clk = ~clk;

   usrt_tx_shifter #(.CLKS_PER_BIT(N1)) u_dut (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(valid1), .o_Ready(rdy1),
      .i_Data(data), .i_Parity(par), .o_Tx(tx1), .o_Sclk(sclk1),
      .o_Busy(busy1), .o_Done(done1)
   );

   usrt_tx_shifter #(.CLKS_PER_BIT(N2)) u_dut2 (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(valid2), .o_Ready(rdy2),
      .i_Data(data), .i_Parity(par), .o_Tx(tx2), .o_Sclk(sclk2),
      .o_Busy(busy2), .o_Done(done2)
   );

   function automatic obs_t observe(input bit sel);
      obs_t o;
      o = sel ? {tx2, sclk2, done2, busy2, rdy2} : {tx1, sclk1, done1, busy1, rdy1};
      return o;
   endfunction

   // Expected line state for every cycle of one frame, plus DONE and one IDLE cycle.
   function automatic void push_frame(input logic [10:0] f, input bit skip, input int n);
      int   nb;
      logic b;
      nb = skip ? 10 : 11;
      for (int k = 0; k < nb; k++) begin
         b = (skip && k == 9) ? f[0] : f[10-k];
         for (int j = 0; j < n; j++)
            exp_q.push_back({b, (j >= n/2) ? 1'b1 : 1'b0, 1'b0, 1'b1, 1'b0});
      end
      exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
   endfunction

   // Called at a negedge; returns at the negedge of cycle 1 (handshake at edge 0).
   task automatic handshake(input logic [10:0] f, input logic [1:0] p, input bit sel,
                            input string name);
      int t;
      t = 0;
      while (!(sel ? rdy2 : rdy1) && t < 100) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 100) begin
         errors++;
         $display("FAIL %s ready_timeout got=0 exp=1", name);
      end
      data = f;
      par  = p;
      if (sel) valid2 = 1'b1;
      else     valid1 = 1'b1;
      @(negedge clk);
      valid1 = 1'b0;
      valid2 = 1'b0;
   endtask

   task automatic run_frame(input logic [10:0] f, input logic [1:0] p, input bit skip,
                            input bit sel, input string name);
      obs_t e, o;
      int   cyc;
      exp_q.delete();
      push_frame(f, skip, sel ? N2 : N1);
      handshake(f, p, sel, name);
      cyc = 1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = observe(sel);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s cycle=%0d got(tx,sclk,done,busy,rdy)=%b exp=%b", name, cyc, o, e);
         end
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      obs_t o;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         o = observe(s[0]);
         checks++;
         if (o !== 5'b10001) begin
            errors++;
            $display("FAIL reset_state dut%0d got=%b exp=10001", s, o);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      run_frame(11'h295, PAR_EVEN, 1'b0, 1'b0, "basic");
   endtask

   task automatic test_back_to_back();
      obs_t e, o;
      int   cyc, dones;
      exp_q.delete();
      push_frame(11'h295, 1'b0, N1);
      push_frame(11'h003, 1'b0, N1);
      data = 11'h295;
      par  = PAR_EVEN;
      valid1 = 1'b1;
      @(negedge clk);
      data = 11'h003;
      cyc = 1;
      dones = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = observe(1'b0);
         if (done1) dones++;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL b2b cycle=%0d got(tx,sclk,done,busy,rdy)=%b exp=%b", cyc, o, e);
         end
         if (cyc == 47) valid1 = 1'b0;
         cyc++;
         @(negedge clk);
      end
      checks++;
      if (dones != 2) begin
         errors++;
         $display("FAIL b2b_done_count got=%0d exp=2", dones);
      end
   endtask

   task automatic test_stability();
      obs_t e, o;
      int   cyc;
      exp_q.delete();
      push_frame(11'h295, 1'b0, N1);
      handshake(11'h295, PAR_EVEN, 1'b0, "stability");
      cyc = 1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = observe(1'b0);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL stability cycle=%0d got(tx,sclk,done,busy,rdy)=%b exp=%b", cyc, o, e);
         end
         if (cyc == 10) begin
            data   = 11'h7FF;
            par    = PAR_NONE;
            valid1 = 1'b1;
         end
         if (cyc == 40) valid1 = 1'b0;
         cyc++;
         @(negedge clk);
      end
      par = PAR_EVEN;
   endtask

   task automatic test_reset_mid();
      obs_t e, o;
      int   dones;
      exp_q.delete();
      push_frame(11'h295, 1'b0, N1);
      handshake(11'h295, PAR_EVEN, 1'b0, "rst_mid");
      for (int c = 1; c < 20; c++) begin
         e = exp_q.pop_front();
         o = observe(1'b0);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rst_mid_pre cycle=%0d got=%b exp=%b", c, o, e);
         end
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      o = observe(1'b0);
      checks++;
      if (o !== 5'b10001) begin
         errors++;
         $display("FAIL rst_mid_immediate got(tx,sclk,done,busy,rdy)=%b exp=10001", o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (done1 || busy1) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL rst_mid_no_done got=%0d exp=0", dones);
      end
      run_frame(11'h295, PAR_EVEN, 1'b0, 1'b0, "rst_mid_next");
   endtask

   task automatic test_parity_mode();
`ifdef USRT_TX_SKIP_NOPARITY_EN
      run_frame(11'h295, PAR_NONE, 1'b1, 1'b0, "skip_par_none");
      run_frame(11'h295, PAR_EVEN, 1'b0, 1'b0, "skip_par_even");
      run_frame(11'h297, PAR_ODD,  1'b0, 1'b0, "skip_par_odd");
`else
      run_frame(11'h295, PAR_NONE, 1'b0, 1'b0, "par_none_full");
      run_frame(11'h297, PAR_ODD,  1'b0, 1'b0, "par_odd_full");
`endif
   endtask

   task automatic test_n2_corner();
      run_frame(11'h400, PAR_EVEN, 1'b0, 1'b1, "n2_corner");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_stability();
      test_reset_mid();
      test_parity_mode();
      test_n2_corner();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
